// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - opcodes and state encodings for the UART command sequencer
//
// Purpose: shared constants for uart_cmd_ctrl and uart_tx_sender.
// Ports:   none (package).

package uart_ctrl_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    // Frame-level sequencer states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ADDR  = 3'd3,
        RD_WAIT  = 3'd4,
        TX_REQ   = 3'd5,
        TX_START = 3'd6,
        TX_DONE  = 3'd7
    } ctrl_state_t;

    // Transmit handshake phases inside uart_tx_sender.
    typedef enum logic [1:0] {
        TXS_IDLE  = 2'd0,
        TXS_REQ   = 2'd1,
        TXS_START = 2'd2,
        TXS_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_sender.sv
// rtl/uart_tx_sender.sv - busy-aware one-byte transmit handshake
//
// Purpose: captures a byte on start, waits for the transmitter to be idle,
//          issues a single TX_D_VLD pulse, then follows busy high and low
//          and reports completion with a one-cycle done pulse.
// Ports:
//   clk, rst    block clock, synchronous active-high reset
//   start       one-cycle request; start_data is captured in the same cycle
//   start_data  byte to send
//   busy        transmitter busy flag
//   tx_data     registered byte presented to the transmitter (held until next start)
//   tx_vld      registered one-cycle transmit request
//   done        registered one-cycle pulse once the frame has left the transmitter

module uart_tx_sender
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] start_data,
    input  logic                  busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_vld,
    output logic                  done
);

    tx_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TXS_IDLE;
            tx_data <= '0;
            tx_vld  <= 1'b0;
            done    <= 1'b0;
        end else begin
            tx_vld <= 1'b0;
            done   <= 1'b0;
            case (state)
                TXS_IDLE: begin
                    if (start) begin
                        tx_data <= start_data;
                        state   <= TXS_REQ;
                    end
                end
                TXS_REQ: begin
                    // Only request while the transmitter is idle, so the pulse
                    // can never overlap a frame already in flight.
                    if (!busy) begin
                        tx_vld <= 1'b1;
                        state  <= TXS_START;
                    end
                end
                TXS_START: begin
                    if (busy) begin
                        state <= TXS_DONE;
                    end
                end
                TXS_DONE: begin
                    if (!busy) begin
                        done  <= 1'b1;
                        state <= TXS_IDLE;
                    end
                end
                default: state <= TXS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-frame command sequencer for the register file
//
// Purpose: parses write (0xAA, addr, data) and read (0xBB, addr) frames from
//          the UART receive side, strobes the register file, and returns read
//          data through the UART transmit side.
// Ports:
//   CLK, RST                  block clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD       received byte and its one-cycle valid
//   TX_P_DATA, TX_D_VLD       byte to transmit and one-cycle start request
//   TX_BUSY                   transmitter busy flag
//   RF_ADDR, RF_WR_DATA       register address / write data (hold last latched)
//   RF_WR_EN, RF_RD_EN        one-cycle register strobes
//   RF_RD_DATA, RF_RD_VLD     register read return
//   CMD_ERR                   one-cycle pulse on bad opcode or dropped byte

module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    output logic                  CMD_ERR
);

    ctrl_state_t state;
    logic        rd_capture;
    logic        tx_done;

    // Read data is handed to the sender in the same cycle it is accepted, so
    // TX_P_DATA is loaded on the RF_RD_VLD edge; later RF_RD_VLD pulses are
    // ignored because the state has already left RD_WAIT.
    assign rd_capture = (state == RD_WAIT) && RF_RD_VLD;

    uart_tx_sender #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tx_sender (
        .clk        (CLK),
        .rst        (RST),
        .start      (rd_capture),
        .start_data (RF_RD_DATA),
        .busy       (TX_BUSY),
        .tx_data    (TX_P_DATA),
        .tx_vld     (TX_D_VLD),
        .done       (tx_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            RF_ADDR    <= '0;
            RF_WR_DATA <= '0;
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            CMD_ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_WR) begin
                            state <= WR_ADDR;
                        end else if (RX_P_DATA == CMD_RD) begin
                            state <= RD_ADDR;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    // Back to IDLE on the same edge the strobe rises, so a new
                    // opcode byte in the very next cycle is accepted.
                    if (RX_D_VLD) begin
                        RF_WR_DATA <= RX_P_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RF_RD_EN <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    if (rd_capture) begin
                        state <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    if (TX_D_VLD) begin
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    // A very short busy window can finish before this state
                    // observes it; the sender's done pulse covers that case.
                    if (tx_done) begin
                        state <= IDLE;
                    end else if (TX_BUSY) begin
                        state <= TX_DONE;
                    end
                end
                TX_DONE: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl

module tb_uart_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_busy;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data;
    logic       rf_wr_en;
    logic       rf_rd_en;
    logic [7:0] rf_rd_data;
    logic       rf_rd_vld;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rxv;
        logic [7:0] rxd;
        logic       rdv;
        logic [7:0] rdd;
        logic       busy;
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] wd;
        logic       txv;
        logic [7:0] txd;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    uart_cmd_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_P_DATA  (rx_data),
        .RX_D_VLD   (rx_vld),
        .TX_P_DATA  (tx_data),
        .TX_D_VLD   (tx_vld),
        .TX_BUSY    (tx_busy),
        .RF_ADDR    (rf_addr),
        .RF_WR_DATA (rf_wr_data),
        .RF_WR_EN   (rf_wr_en),
        .RF_RD_EN   (rf_rd_en),
        .RF_RD_DATA (rf_rd_data),
        .RF_RD_VLD  (rf_rd_vld),
        .CMD_ERR    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rxv, logic [7:0] rxd, logic rdv, logic [7:0] rdd,
                                logic busy, logic wr, logic rd, logic [3:0] addr,
                                logic [7:0] wd, logic txv, logic [7:0] txd, logic err);
        vec_t v;
        v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd; v.busy = busy;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.txv = txv; v.txd = txd; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic drive(input logic rxv, input logic [7:0] rxd, input logic rdv,
                         input logic [7:0] rdd, input logic busy);
        @(negedge clk);
        rx_vld = rxv; rx_data = rxd; rf_rd_vld = rdv; rf_rd_data = rdd; tx_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " wr_en"},   {7'd0, rf_wr_en}, {7'd0, v.wr});
        chk({tag, " rd_en"},   {7'd0, rf_rd_en}, {7'd0, v.rd});
        chk({tag, " addr"},    {4'd0, rf_addr},  {4'd0, v.addr});
        chk({tag, " wr_data"}, rf_wr_data,       v.wd);
        chk({tag, " tx_vld"},  {7'd0, tx_vld},   {7'd0, v.txv});
        chk({tag, " tx_data"}, tx_data,          v.txd);
        chk({tag, " cmd_err"}, {7'd0, cmd_err},  {7'd0, v.err});
    endtask

    initial begin
        int pulses;
        rst = 1'b1; rx_vld = 0; rx_data = 0; rf_rd_vld = 0; rf_rd_data = 0; tx_busy = 0;

        //            rxv rxd    rdv rdd    bsy  wr rd addr wd     txv txd    err
        vecs.push_back(mk(1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h03, 0, 8'h00, 0,  0, 0, 4'h3, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h5A, 0, 8'h00, 0,  1, 0, 4'h3, 8'h5A, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h3, 8'h5A, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h11, 0, 8'h00, 0,  0, 0, 4'h3, 8'h5A, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h3, 8'h5A, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h3, 8'h5A, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h01, 0, 8'h00, 0,  0, 0, 4'h1, 8'h5A, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h22, 0, 8'h00, 0,  1, 0, 4'h1, 8'h22, 0, 8'h00, 0));
        // back-to-back write; address byte 0x1F truncates to 0xF
        vecs.push_back(mk(1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h1, 8'h22, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h1F, 0, 8'h00, 0,  0, 0, 4'hF, 8'h22, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h44, 0, 8'h00, 0,  1, 0, 4'hF, 8'h44, 0, 8'h00, 0));
        // read addr 7, data 0xC3, 0x55 dropped during the transmit handshake
        vecs.push_back(mk(1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'hF, 8'h44, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h07, 0, 8'h00, 0,  0, 1, 4'h7, 8'h44, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h7, 8'h44, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h7, 8'h44, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 8'hC3, 0,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h7, 8'h44, 1, 8'hC3, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        vecs.push_back(mk(1, 8'h55, 0, 8'h00, 1,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        // stray read-valid in IDLE is ignored
        vecs.push_back(mk(0, 8'h00, 1, 8'h99, 0,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        // read addr 2 with the transmitter busy when data returns
        vecs.push_back(mk(1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h7, 8'h44, 0, 8'hC3, 0));
        vecs.push_back(mk(1, 8'h02, 0, 8'h00, 0,  0, 1, 4'h2, 8'h44, 0, 8'hC3, 0));
        vecs.push_back(mk(0, 8'h00, 1, 8'h3C, 1,  0, 0, 4'h2, 8'h44, 0, 8'h3C, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset wr_en",   {7'd0, rf_wr_en}, 8'h00);
        chk("reset rd_en",   {7'd0, rf_rd_en}, 8'h00);
        chk("reset tx_vld",  {7'd0, tx_vld},   8'h00);
        chk("reset cmd_err", {7'd0, cmd_err},  8'h00);
        chk("reset tx_data", tx_data,          8'h00);
        chk("reset addr",    {4'd0, rf_addr},  8'h00);
        chk("reset wr_data", rf_wr_data,       8'h00);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].rxv, vecs[i].rxd, vecs[i].rdv, vecs[i].rdd, vecs[i].busy);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // transmitter stays busy 20 cycles: no request may appear
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 8'h00, 0, 8'h00, 1);
            if (tx_vld) pulses++;
        end
        chk("busy hold no tx_vld", pulses[7:0], 8'd0);
        drive(0, 8'h00, 0, 8'h00, 0);
        chk("tx_vld after busy drop", {7'd0, tx_vld}, 8'h01);
        chk("tx_data on request", tx_data, 8'h3C);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, 0, 8'h00, 1);
            if (tx_vld) pulses++;
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 0, 8'h00, 0);
            if (tx_vld) pulses++;
        end
        chk("single tx_vld per read", pulses[7:0], 8'd0);
        drive(1, 8'hAA, 0, 8'h00, 0);
        drive(1, 8'h05, 0, 8'h00, 0);
        drive(1, 8'h66, 0, 8'h00, 0);
        chk("post-read write wr_en", {7'd0, rf_wr_en}, 8'h01);
        chk("post-read write addr",  {4'd0, rf_addr},  8'h05);
        chk("post-read write data",  rf_wr_data,       8'h66);

        // reset in the middle of a write frame
        drive(1, 8'hAA, 0, 8'h00, 0);
        drive(1, 8'h02, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1; rx_vld = 0;
        @(posedge clk);
        #1;
        chk("mid-frame reset wr_en", {7'd0, rf_wr_en}, 8'h00);
        chk("mid-frame reset addr",  {4'd0, rf_addr},  8'h00);
        chk("mid-frame reset data",  rf_wr_data,       8'h00);
        chk("mid-frame reset tx",    tx_data,          8'h00);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        drive(0, 8'h00, 0, 8'h00, 0);
        if (rf_wr_en) pulses++;
        drive(1, 8'hAA, 0, 8'h00, 0);
        if (rf_wr_en) pulses++;
        drive(1, 8'h02, 0, 8'h00, 0);
        if (rf_wr_en) pulses++;
        chk("no write from partial frame", pulses[7:0], 8'd0);
        drive(1, 8'h99, 0, 8'h00, 0);
        chk("after reset wr_en", {7'd0, rf_wr_en}, 8'h01);
        chk("after reset addr",  {4'd0, rf_addr},  8'h02);
        chk("after reset data",  rf_wr_data,       8'h99);
        drive(0, 8'h00, 0, 8'h00, 0);
        chk("after reset wr_en drop", {7'd0, rf_wr_en}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receive/transmit datapaths and the register file. Parses byte frames arriving on the UART receive side into register write and register read commands, drives the register-file port, and returns read data through the UART transmit side with a busy-aware handshake. Sits directly above the UART top level in the SoC, in the same clock domain as the register file.

## Interface
- DATA_WIDTH, 8, UART byte width and register data width.
- ADDR_WIDTH, 4, register-file address width; address byte is truncated to the low ADDR_WIDTH bits.

- CLK  in  1  block clock; all RX/TX handshake signals are already synchronous to it.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid this cycle.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle request to start a transmission.
- TX_BUSY  in  1  high while the transmitter is sending a frame.
- RF_ADDR  out  ADDR_WIDTH  register address.
- RF_WR_DATA  out  DATA_WIDTH  write data.
- RF_WR_EN  out  1  one-cycle write strobe.
- RF_RD_EN  out  1  one-cycle read strobe.
- RF_RD_DATA  in  DATA_WIDTH  read data.
- RF_RD_VLD  in  1  RF_RD_DATA valid (any latency ≥1 cycle after RF_RD_EN).
- CMD_ERR  out  1  one-cycle pulse: unknown opcode or byte dropped.

## Operation
- Frames: write = 0xAA, addr, data; read = 0xBB, addr. Any other first byte: pulse CMD_ERR, stay IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_REQ, TX_START, TX_DONE.
- IDLE: on RX_D_VLD with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR.
- WR_ADDR: on RX_D_VLD latch address -> WR_DATA. WR_DATA: on RX_D_VLD latch data, assert RF_WR_EN next cycle -> IDLE.
- RD_ADDR: on RX_D_VLD latch address, assert RF_RD_EN next cycle -> RD_WAIT.
- RD_WAIT: on RF_RD_VLD latch RF_RD_DATA into TX_P_DATA -> TX_REQ.
- TX_REQ: when TX_BUSY low, pulse TX_D_VLD -> TX_START. TX_START: wait TX_BUSY high -> TX_DONE. TX_DONE: wait TX_BUSY low -> IDLE.
- RX_D_VLD arriving in RD_WAIT, TX_REQ, TX_START, TX_DONE: byte discarded, CMD_ERR pulses same cycle as registered response (one cycle after RX_D_VLD).
- RF_RD_VLD outside RD_WAIT is ignored.
- RF_ADDR and RF_WR_DATA hold last latched values; TX_P_DATA holds until next read completes.

## Timing
- Reset values: TX_P_DATA=0, TX_D_VLD=0, RF_ADDR=0, RF_WR_DATA=0, RF_WR_EN=0, RF_RD_EN=0, CMD_ERR=0, state IDLE.
- All outputs registered. RF_WR_EN high exactly in cycle N+1 where N is the data byte's RX_D_VLD cycle; RF_ADDR/RF_WR_DATA valid in that cycle.
- RF_RD_EN high in cycle N+1 after the address byte; TX_D_VLD no earlier than 1 cycle after RF_RD_VLD.
- TX_D_VLD never asserted while TX_BUSY is high; exactly one pulse per read.
- Back-to-back write frames with consecutive RX_D_VLD pulses accepted without loss (IDLE re-entered the cycle RF_WR_EN asserts).
- RST mid-frame: partial frame discarded, all strobes deasserted next cycle, no TX_D_VLD emitted.

## Structure
- Package uart_ctrl_pkg: opcode constants CMD_WR=8'hAA, CMD_RD=8'hBB, state enum.
- One sub-module natural: uart_tx_sender (TX_REQ/TX_START/TX_DONE handshake, byte in + start -> TX_D_VLD, done pulse).

## Test plan
- Write 0xAA,0x03,0x5A -> single RF_WR_EN with RF_ADDR=3, RF_WR_DATA=0x5A one cycle after third byte.
- Read 0xBB,0x07, RF_RD_VLD with 0xC3 after 3 cycles -> RF_RD_EN once with RF_ADDR=7, then one TX_D_VLD with TX_P_DATA=0xC3.
- Read with TX_BUSY held high 20 cycles -> TX_D_VLD delayed until TX_BUSY low; no pulse while busy.
- Opcode 0x11 -> CMD_ERR pulse, no RF strobe; following 0xAA,0x01,0x22 writes correctly.
- Byte 0x55 during TX_START -> CMD_ERR pulse, byte dropped, read response completes unchanged.
- RST asserted after 0xAA,0x02 -> no RF_WR_EN; subsequent 0xAA,0x02,0x99 writes 0x99 to addr 2.
